// File: rtl/sum_seq_pkg.sv
// Shared types and limits for the summing sequencer: FSM state encoding,
// read-latency bounds and the address-generator command set.
package sum_seq_pkg;

   localparam int unsigned STATE_W    = 4;
   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned LAT_CNT_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 4'd0,
      S_CLR   = 4'd1,
      S_ADDR  = 4'd2,
      S_RD    = 4'd3,
      S_LOAD  = 4'd4,
      S_RDOFF = 4'd5,
      S_XFER  = 4'd6,
      S_GAP   = 4'd7,
      S_WR    = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      ADDR_HOLD  = 2'd0,
      ADDR_FIRST = 2'd1,
      ADDR_NEXT  = 2'd2
   } addr_op_t;

endpackage

// File: rtl/sum_addr_gen.sv
// Address generator: holds the captured range bounds, steps the memory
// address with natural wrap at 2^ADDR_W and flags the last word of a pass.
module sum_addr_gen
   import sum_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic [ADDR_W-1:0] addr_first,
   input  logic [ADDR_W-1:0] addr_last,
   input  addr_op_t          op,
   output logic [ADDR_W-1:0] address,
   output logic              last_c
);

   logic [ADDR_W-1:0] first_q;
   logic [ADDR_W-1:0] last_q;

   // Range bounds are frozen for the whole run once a start is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_q <= '0;
         last_q  <= '0;
      end else if (capture) begin
         first_q <= addr_first;
         last_q  <= addr_last;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address <= '0;
      end else begin
         case (op)
            ADDR_FIRST: address <= first_q;
            ADDR_NEXT:  address <= address + ADDR_W'(1);
            default:    address <= address;
         endcase
      end
   end

   // Stepping until address == last gives ((last-first) mod 2^ADDR_W)+1 words.
   assign last_c = (address == last_q);

endmodule

// File: rtl/sum_seq_ctrl.sv
// Sequencer for a read-accumulate-transfer-write loop over a memory address
// range, single pass or continuous, with registered strobe outputs.
module sum_seq_ctrl
   import sum_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic              stop,
   input  logic [ADDR_W-1:0] addr_first,
   input  logic [ADDR_W-1:0] addr_last,
   output logic [ADDR_W-1:0] address,
   output logic              rden,
   output logic              wren,
   output logic              load,
   output logic              transf,
   output logic              clear,
   output logic              ready,
   output logic              done
);

   localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                 (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam logic [LAT_CNT_W-1:0] LAT_END = LAT_CNT_W'(LAT - 1);

   state_t               state;
   state_t               state_next;
   addr_op_t             addr_op;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic                 mode_q;
   logic                 stop_q;
   logic                 capture_c;
   logic                 last_c;

   logic rden_d, wren_d, load_d, transf_d, clear_d, ready_d, done_d;

   assign capture_c = (state == S_IDLE) && start;

   sum_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .capture    (capture_c),
      .addr_first (addr_first),
      .addr_last  (addr_last),
      .op         (addr_op),
      .address    (address),
      .last_c     (last_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next state; the registered done flag marks the final WR of a run.
   always_comb begin
      state_next = state;
      addr_op    = ADDR_HOLD;
      case (state)
         S_IDLE:  if (start) state_next = S_CLR;
         S_CLR: begin
            state_next = S_ADDR;
            addr_op    = ADDR_FIRST;
         end
         S_ADDR:  state_next = S_RD;
         S_RD:    if (lat_cnt == LAT_END) state_next = S_LOAD;
         S_LOAD:  state_next = S_RDOFF;
         S_RDOFF: state_next = S_XFER;
         S_XFER:  state_next = S_GAP;
         S_GAP:   state_next = S_WR;
         S_WR: begin
            if (done) begin
               state_next = S_IDLE;
            end else begin
               state_next = S_ADDR;
               addr_op    = last_c ? ADDR_FIRST : ADDR_NEXT;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Strobes decode the upcoming state so the registered copies line up with it.
   always_comb begin
      rden_d   = 1'b0;
      wren_d   = 1'b0;
      load_d   = 1'b0;
      transf_d = 1'b0;
      clear_d  = 1'b0;
      done_d   = 1'b0;
      ready_d  = (state_next == S_IDLE);
      case (state_next)
         S_CLR:   clear_d  = 1'b1;
         S_RD:    rden_d   = 1'b1;
         S_LOAD: begin
            rden_d = 1'b1;
            load_d = 1'b1;
         end
         S_RDOFF: rden_d   = 1'b1;
         S_XFER:  transf_d = 1'b1;
         S_WR: begin
            wren_d = 1'b1;
            done_d = (last_c && !mode_q) || stop_q || stop;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rden   <= 1'b0;
         wren   <= 1'b0;
         load   <= 1'b0;
         transf <= 1'b0;
         clear  <= 1'b0;
         ready  <= 1'b1;
         done   <= 1'b0;
      end else begin
         rden   <= rden_d;
         wren   <= wren_d;
         load   <= load_d;
         transf <= transf_d;
         clear  <= clear_d;
         ready  <= ready_d;
         done   <= done_d;
      end
   end

   // Read-latency counter, run mode and the sticky stop request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_cnt <= '0;
         mode_q  <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         lat_cnt <= (state == S_RD) ? lat_cnt + LAT_CNT_W'(1) : '0;
         if (capture_c) mode_q <= mode;
         if (state_next == S_IDLE)               stop_q <= 1'b0;
         else if (state != S_IDLE && stop)       stop_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Directed bench for sum_seq_ctrl: one RD_LAT=1 and one RD_LAT=3 instance
// share stimulus; a per-cycle recorder and strobe-ordering monitor feed checks.
module tb_sum_seq_ctrl;

   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic              stop = 1'b0;
   logic [ADDR_W-1:0] addr_first = '0;
   logic [ADDR_W-1:0] addr_last = '0;

   logic [ADDR_W-1:0] address, address3;
   logic rden, wren, load, transf, clear, ready, done;
   logic rden3, wren3, load3, transf3, clear3, ready3, done3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sum_seq_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .stop(stop),
      .addr_first(addr_first), .addr_last(addr_last), .address(address),
      .rden(rden), .wren(wren), .load(load), .transf(transf), .clear(clear),
      .ready(ready), .done(done)
   );

   sum_seq_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .stop(stop),
      .addr_first(addr_first), .addr_last(addr_last), .address(address3),
      .rden(rden3), .wren(wren3), .load(load3), .transf(transf3), .clear(clear3),
      .ready(ready3), .done(done3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-cycle recording of run events (sampled mid-cycle).
   int cyc = 0;
   int clr_n, clr_cyc, done_n, done_cyc;
   int wr_addr[$];
   int clr3_cyc, done3_n, done3_cyc, rden3_n, load3_pos, wren3_n;

   task automatic clear_rec();
      clr_n = 0; clr_cyc = 0; done_n = 0; done_cyc = 0;
      wr_addr.delete();
      clr3_cyc = 0; done3_n = 0; done3_cyc = 0; rden3_n = 0; load3_pos = 0; wren3_n = 0;
   endtask

   logic mon_valid = 1'b0;
   logic [ADDR_W-1:0] p_address, p_address3;
   logic p_rden, p_wren, p_transf, p_rden3, p_wren3, p_transf3;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         if (clear) begin clr_n++; clr_cyc = cyc; end
         if (wren) wr_addr.push_back(int'(address));
         if (done) begin done_n++; done_cyc = cyc; end
         if (clear3) clr3_cyc = cyc;
         if (rden3) rden3_n++;
         if (load3) load3_pos = rden3_n;
         if (wren3) wren3_n++;
         if (done3) begin done3_n++; done3_cyc = cyc; end
         chk("load_transf_excl", {31'd0, load & transf}, 0);
         chk("load_transf_excl3", {31'd0, load3 & transf3}, 0);
         if (mon_valid) begin
            if (rden !== p_rden)   chk("addr_at_rden_edge", address, p_address);
            if (wren !== p_wren)   chk("transf_at_wren_edge", {31'd0, transf | p_transf}, 0);
            if (rden3 !== p_rden3) chk("addr_at_rden_edge3", address3, p_address3);
            if (wren3 !== p_wren3) chk("transf_at_wren_edge3", {31'd0, transf3 | p_transf3}, 0);
         end
         mon_valid = 1'b1;
      end else begin
         mon_valid = 1'b0;
      end
      p_address = address;  p_rden = rden;  p_wren = wren;  p_transf = transf;
      p_address3 = address3; p_rden3 = rden3; p_wren3 = wren3; p_transf3 = transf3;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input logic m, input int f, input int l);
      mode = m;
      addr_first = ADDR_W'(f);
      addr_last = ADDR_W'(l);
      start = 1'b1;
      clear_rec();
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int k = 0;
      while (done_n == 0 && k < bound) begin tick(); k++; end
      chk(tag, done_n, 1);
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k = 0;
      while (!(ready && ready3) && k < bound) begin tick(); k++; end
      chk(tag, {31'd0, ready & ready3}, 1);
   endtask

   task automatic chk_addrs(input string tag, input int exp[$]);
      chk({tag, "_count"}, wr_addr.size(), exp.size());
      foreach (exp[i]) chk(tag, (i < wr_addr.size()) ? wr_addr[i] : -1, exp[i]);
   endtask

   initial begin
      int k;
      int exp[$];
      clear_rec();

      // Reset state
      tick(2);
      chk("rst_ready", {31'd0, ready}, 1);
      chk("rst_address", address, 0);
      chk("rst_strobes", {rden, wren, load, transf, clear, done}, 0);

      // Full range 0..31 single pass, start on the first edge after release
      @(negedge clk);
      reset = 1'b1;
      launch(1'b0, 0, 31);
      chk("t1_clear_first_edge", {31'd0, clear}, 1);
      chk("t1_ready_low", {31'd0, ready}, 0);
      wait_done("t1_done", 400);
      chk("t1_span", done_cyc - clr_cyc, 224);
      exp.delete();
      for (int i = 0; i < 32; i++) exp.push_back(i);
      chk_addrs("t1_addr", exp);
      tick();
      chk("t1_ready", {31'd0, ready}, 1);
      tick(10);
      chk("t1_no_extra_wr", wr_addr.size(), 32);
      chk("t1_done_once", done_n, 1);
      chk("t1_addr_hold", address, 31);
      wait_idle("t1_idle", 400);

      // Wrapping range 30..1, with an ignored start mid-run
      launch(1'b0, 30, 1);
      tick(3);
      mode = 1'b1; addr_first = 5'd5; addr_last = 5'd5; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t2_done", 100);
      chk("t2_span", done_cyc - clr_cyc, 28);
      exp = '{30, 31, 0, 1};
      chk_addrs("t2_addr", exp);
      chk("t2_clear_once", clr_n, 1);
      wait_idle("t2_idle", 100);

      // Single word 5..5, RD_LAT=1 and RD_LAT=3
      launch(1'b0, 5, 5);
      wait_done("t3_done", 50);
      chk("t3_span", done_cyc - clr_cyc, 7);
      exp = '{5};
      chk_addrs("t3_addr", exp);
      k = 0;
      while (done3_n == 0 && k < 50) begin tick(); k++; end
      chk("t3_done3", done3_n, 1);
      chk("t3_rden3_cycles", rden3_n, 5);
      chk("t3_load3_pos", load3_pos, 4);
      chk("t3_wren3", wren3_n, 1);
      chk("t3_span3", done3_cyc - clr3_cyc, 9);
      wait_idle("t3_idle", 50);

      // Continuous 2..3, stop during the second pass at address 2
      launch(1'b1, 2, 3);
      k = 0;
      while (wr_addr.size() < 2 && k < 100) begin tick(); k++; end
      chk("t4_pass1", wr_addr.size(), 2);
      k = 0;
      while (!(rden && address == 5'd2) && k < 20) begin tick(); k++; end
      chk("t4_at_addr2", address, 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("t4_done", 100);
      exp = '{2, 3, 2};
      chk_addrs("t4_addr", exp);
      chk("t4_clear_once", clr_n, 1);
      tick(2);
      chk("t4_ready", {31'd0, ready}, 1);
      tick(10);
      chk("t4_no_extra_wr", wr_addr.size(), 3);
      wait_idle("t4_idle", 100);

      // Reset during LOAD, then a clean restart
      launch(1'b0, 0, 3);
      k = 0;
      while (!load && k < 20) begin tick(); k++; end
      chk("t5_in_load", {31'd0, load}, 1);
      reset = 1'b0;
      #1;
      chk("t5_rst_strobes", {rden, wren, load, transf, clear, done}, 0);
      chk("t5_rst_address", address, 0);
      chk("t5_rst_ready", {31'd0, ready}, 1);
      chk("t5_rst_strobes3", {rden3, wren3, load3, transf3, clear3, done3}, 0);
      @(negedge clk);
      reset = 1'b1;
      launch(1'b0, 4, 6);
      chk("t5_restart_clear", {31'd0, clear}, 1);
      wait_done("t5_done", 100);
      chk("t5_span", done_cyc - clr_cyc, 21);
      exp = '{4, 5, 6};
      chk_addrs("t5_addr", exp);
      chk("t5_clear_once", clr_n, 1);
      wait_idle("t5_idle", 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
